// File: rtl/cmd_sched.sv
// Round-robin scheduler that shares one snd_cmd among NREQ requesters, launching each
// granted command with a per-attempt response timeout and bounded retry.
module cmd_sched #(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = 1000,
  parameter int MAX_RETRY   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [5*NREQ-1:0] req_start,
  input  logic [4*NREQ-1:0] req_len,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [NREQ-1:0]   fail,
  output logic              busy,
  output logic              send,
  output logic [4:0]        cmd_start,
  output logic [3:0]        cmd_len,
  input  logic              resp_rcvd,
  output logic [1:0]        state_dbg
);
  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [2:0]      RETRY_MAX  = 3'(MAX_RETRY);
  localparam logic [IW-1:0]   ID_LAST    = IW'(NREQ - 1);
  localparam logic [NREQ-1:0] GNT_ONE    = NREQ'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   id, id_nxt;
  logic [IW-1:0]   rr_ptr, rr_ptr_nxt;
  logic [IW-1:0]   id_inc;
  logic [2:0]      retry_cnt, retry_nxt;
  logic [TW-1:0]   timer, timer_nxt;
  logic [NREQ-1:0] gnt_nxt, done_nxt, fail_nxt;
  logic [4:0]      start_nxt;
  logic [3:0]      len_nxt;
  logic            pick_vld;
  logic [IW-1:0]   pick_id;

  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  // First requesting index at or after rr_ptr, wrapping modulo NREQ
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!pick_vld && req[rr_idx(rr_ptr, k)]) begin
        pick_vld = 1'b1;
        pick_id  = rr_idx(rr_ptr, k);
      end
    end
  end

  assign id_inc = (id == ID_LAST) ? '0 : id + 1'b1;

  always_comb begin
    state_nxt  = state;
    id_nxt     = id;
    rr_ptr_nxt = rr_ptr;
    retry_nxt  = retry_cnt;
    timer_nxt  = timer;
    gnt_nxt    = gnt;
    done_nxt   = '0;
    fail_nxt   = '0;
    start_nxt  = cmd_start;
    len_nxt    = cmd_len;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          id_nxt    = pick_id;
          gnt_nxt   = GNT_ONE << pick_id;
          start_nxt = req_start[5*int'(pick_id) +: 5];
          len_nxt   = req_len[4*int'(pick_id) +: 4];
          retry_nxt = '0;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        timer_nxt = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        timer_nxt = timer + 1'b1;
        // A response arriving on the timeout cycle still counts as success
        if (resp_rcvd) begin
          done_nxt   = gnt;
          gnt_nxt    = '0;
          rr_ptr_nxt = id_inc;
          state_nxt  = IDLE;
        end else if (timer == TIMER_LAST) begin
          if (retry_cnt < RETRY_MAX) begin
            retry_nxt = retry_cnt + 1'b1;
            state_nxt = LAUNCH;
          end else begin
            fail_nxt   = gnt;
            gnt_nxt    = '0;
            rr_ptr_nxt = id_inc;
            state_nxt  = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      id        <= '0;
      rr_ptr    <= '0;
      retry_cnt <= '0;
      timer     <= '0;
      gnt       <= '0;
      done      <= '0;
      fail      <= '0;
      cmd_start <= '0;
      cmd_len   <= '0;
    end else begin
      state     <= state_nxt;
      id        <= id_nxt;
      rr_ptr    <= rr_ptr_nxt;
      retry_cnt <= retry_nxt;
      timer     <= timer_nxt;
      gnt       <= gnt_nxt;
      done      <= done_nxt;
      fail      <= fail_nxt;
      cmd_start <= start_nxt;
      cmd_len   <= len_nxt;
    end
  end

  assign send      = (state == LAUNCH);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_cmd_sched.sv
// Scoreboard bench for cmd_sched: per-phase service order and outcomes are predicted from
// round-robin and retry rules, then checked by a monitor as send/done/fail appear.
module tb_cmd_sched;
  localparam int NREQ = 4;
  localparam int T    = 100;
  localparam int MR   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [5*NREQ-1:0] req_start;
  logic [4*NREQ-1:0] req_len;
  logic [NREQ-1:0]   gnt, done, fail;
  logic              busy, send;
  logic [4:0]        cmd_start;
  logic [3:0]        cmd_len;
  logic              resp_bfm, resp_dir;
  logic [1:0]        state_dbg;

  cmd_sched #(.NREQ(NREQ), .TIMEOUT_CYC(T), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst(rst), .req(req), .req_start(req_start), .req_len(req_len),
    .gnt(gnt), .done(done), .fail(fail), .busy(busy), .send(send),
    .cmd_start(cmd_start), .cmd_len(cmd_len), .resp_rcvd(resp_bfm | resp_dir),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [2:0] id;
    logic [4:0] st;
    logic [3:0] ln;
    logic       ok;
    logic [3:0] nsend;
    logic [7:0] delay;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   dir_mode = 1'b0;
  int   model_rr = 0;

  int         p_att[NREQ];
  int         p_delay[NREQ];
  bit         p_drop[NREQ];
  logic [4:0] p_st[NREQ];
  logic [3:0] p_ln[NREQ];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic summary_and_finish();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  // Monitor: pops one expectation per completed transaction
  initial begin
    bit   in_txn;
    int   sends, last_send;
    exp_t e;
    in_txn = 1'b0; sends = 0; last_send = 0;
    forever begin
      @(negedge clk);
      if (rst || dir_mode) begin
        in_txn = 1'b0; sends = 0;
        continue;
      end
      if (send) begin
        if (exp_q.size() == 0) check("unexpected_send", 32'd1, 32'd0);
        else begin
          e = exp_q[0];
          check("busy_in_launch", busy, 1);
          check("gnt", gnt, onehot(e.id));
          check("cmd_start", cmd_start, e.st);
          check("cmd_len", cmd_len, e.ln);
          if (in_txn) check("send_spacing", cyc - last_send, T + 1);
          in_txn = 1'b1; sends++; last_send = cyc;
        end
      end
      if ((done | fail) != '0) begin
        if (exp_q.size() == 0) check("unexpected_done_fail", {done, fail}, 0);
        else begin
          e = exp_q.pop_front();
          check("done", done, e.ok ? onehot(e.id) : 0);
          check("fail", fail, e.ok ? 0 : onehot(e.id));
          check("attempts", sends, e.nsend);
          check("end_latency", cyc - last_send, e.ok ? int'(e.delay) + 1 : T + 1);
          check("gnt_released", gnt, 0);
          check("busy_released", busy, 0);
          in_txn = 1'b0; sends = 0;
        end
      end
    end
  end

  // Responder: answers the planned attempt after its delay, plus stray pulses that must be ignored
  initial begin
    int   att, cd;
    exp_t e;
    resp_bfm = 1'b0; att = 0; cd = 0;
    forever begin
      @(negedge clk);
      resp_bfm = 1'b0;
      if (rst || dir_mode) begin
        att = 0; cd = 0;
        continue;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) resp_bfm = 1'b1;
      end
      if ((done | fail) != '0) att = 0;
      if (send && exp_q.size() != 0) begin
        e = exp_q[0];
        att++;
        if (e.ok && att == int'(e.nsend)) cd = int'(e.delay);
        else if ($urandom_range(0, 3) == 0) resp_bfm = 1'b1;
      end else if (!busy && $urandom_range(0, 5) == 0) begin
        resp_bfm = 1'b1;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    summary_and_finish();
  end

  // ---------------- driver tasks ----------------
  task automatic set_plan(input int id, input int st, input int ln, input int att,
                          input int delay, input bit drop);
    p_st[id] = 5'(st); p_ln[id] = 4'(ln);
    p_att[id] = att; p_delay[id] = delay; p_drop[id] = drop;
  endtask

  task automatic rand_plans();
    for (int i = 0; i < NREQ; i++) begin
      p_st[i]  = 5'($urandom);
      p_ln[i]  = 4'($urandom);
      p_att[i] = $urandom_range(0, MR + 1);
      case ($urandom_range(0, 3))
        0:       p_delay[i] = 1;
        1:       p_delay[i] = T;
        default: p_delay[i] = $urandom_range(1, T);
      endcase
      p_drop[i] = ($urandom_range(0, 3) == 0);
    end
  endtask

  // Called at a negedge with the scheduler idle and req == 0
  task automatic run_phase(input logic [NREQ-1:0] mask);
    int   order[$];
    int   id, cur, served, budget;
    bit   cur_first;
    exp_t e;
    order = {};
    for (int k = 0; k < NREQ; k++) begin
      id = (model_rr + k) % NREQ;
      if (mask[id]) begin
        order.push_back(id);
        e.id    = 3'(id);
        e.st    = p_st[id];
        e.ln    = p_ln[id];
        e.ok    = (p_att[id] != 0);
        e.nsend = e.ok ? 4'(p_att[id]) : 4'(MR + 1);
        e.delay = 8'(p_delay[id]);
        exp_q.push_back(e);
        req_start[5*id +: 5] = p_st[id];
        req_len[4*id +: 4]   = p_ln[id];
      end
    end
    model_rr = (order[$] + 1) % NREQ;
    req = mask;
    @(negedge clk);
    check("send_latency", send, 1);
    served = 0; budget = 0; cur_first = 1'b1;
    while (served < order.size() && budget < 400 * NREQ) begin
      cur = order[served];
      if (send) begin
        // The owner's slice is already latched; changing it must not matter
        req_start[5*cur +: 5] = 5'($urandom);
        req_len[4*cur +: 4]   = 4'($urandom);
        if (cur_first && p_drop[cur]) req[cur] = 1'b0;
        cur_first = 1'b0;
      end
      if ((done | fail) != '0) begin
        req = req & ~(done | fail);
        served++;
        cur_first = 1'b1;
      end
      @(negedge clk);
      budget++;
    end
    check("phase_served", served, order.size());
    if (served < order.size()) summary_and_finish();
  endtask

  task automatic reset_mid_wait(input logic [1:0] idle_code);
    int guard;
    dir_mode = 1'b1;
    req_start[10 +: 5] = 5'd21;
    req_len[8 +: 4]    = 4'd7;
    req = 4'b0100;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!send && guard < 10);
    check("rst_test_send", send, 1);
    repeat (3) @(negedge clk);
    check("rst_test_in_wait", busy, 1);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_gnt", gnt, 0);
    check("rst_done_fail", {done, fail}, 0);
    check("rst_busy_send", {busy, send}, 0);
    check("rst_cmd", {cmd_start, cmd_len}, 0);
    check("rst_state", state_dbg, idle_code);
    resp_dir = 1'b1;
    @(negedge clk);
    resp_dir = 1'b0;
    repeat (4) begin
      check("rst_no_pulse", {done, fail}, 0);
      check("rst_stays_idle", busy, 0);
      @(negedge clk);
    end
    dir_mode = 1'b0;
    model_rr = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [1:0] idle_code;
    rst = 1'b1; req = '0; req_start = '0; req_len = '0; resp_dir = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_gnt", gnt, 0);
    check("reset_done", done, 0);
    check("reset_fail", fail, 0);
    check("reset_busy_send", {busy, send}, 0);
    check("reset_cmd", {cmd_start, cmd_len}, 0);
    idle_code = state_dbg;
    @(negedge clk);

    // All four requesting, quick responses: order 0,1,2,3
    for (int i = 0; i < NREQ; i++) set_plan(i, 4 + i, 1 + i, 1, 5, 1'b0);
    run_phase(4'b1111);

    // Single requester 1, start 8 len 3, response 50 cycles after send
    set_plan(1, 8, 3, 1, 50, 1'b0);
    run_phase(4'b0010);

    reset_mid_wait(idle_code);

    // Pointer restarted at 0 after reset
    for (int i = 0; i < NREQ; i++) set_plan(i, 16 + i, 9 + i, 1, $urandom_range(1, 20), 1'b0);
    run_phase(4'b1111);

    // No response at all: three attempts then fail
    set_plan(2, 3, 5, 0, 1, 1'b0);
    run_phase(4'b0100);

    // Response during the second attempt
    set_plan(0, 30, 12, 2, 40, 1'b0);
    run_phase(4'b0001);

    // Response on the last timer cycle of the final attempt and of the first
    set_plan(3, 17, 2, MR + 1, T, 1'b0);
    run_phase(4'b1000);
    set_plan(1, 9, 14, 1, T, 1'b0);
    run_phase(4'b0010);

    // Owner drops req mid-WAIT; others wait their turn
    for (int i = 0; i < NREQ; i++) set_plan(i, 2 * i, 15 - i, 2, 60, 1'b1);
    run_phase(4'b1011);

    for (int ph = 0; ph < 25; ph++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      rand_plans();
      run_phase(4'($urandom_range(1, (1 << NREQ) - 1)));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    summary_and_finish();
  end

endmodule
